// File: rtl/alu_serial_seq_pkg.sv
// alu_defs: shared op codes, slice selects, FSM states and decode for the serial ALU
package alu_defs;
  localparam int DEF_WIDTH = 32;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [1:0] SEL_AND  = 2'd0;
  localparam logic [1:0] SEL_OR   = 2'd1;
  localparam logic [1:0] SEL_ADD  = 2'd2;
  localparam logic [1:0] SEL_LESS = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef struct packed {
    logic       valid;
    logic       arith;
    logic       slt;
    logic       a_inv;
    logic       b_inv;
    logic [1:0] sel;
  } ctl_t;
  // arith marks ops that report overflow; slt marks the set-on-less fix-up
  function automatic ctl_t decode(input logic [3:0] op);
    ctl_t c;
    c = '0;
    c.valid = 1'b1;
    case (op)
      OP_AND: c.sel = SEL_AND;
      OP_OR:  c.sel = SEL_OR;
      OP_ADD: begin c.sel = SEL_ADD; c.arith = 1'b1; end
      OP_SUB: begin c.sel = SEL_ADD; c.arith = 1'b1; c.b_inv = 1'b1; end
      OP_SLT: begin c.sel = SEL_ADD; c.slt = 1'b1; c.b_inv = 1'b1; end
      OP_NOR: begin c.sel = SEL_AND; c.a_inv = 1'b1; c.b_inv = 1'b1; end
      default: c.valid = 1'b0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: combinational 1-bit ALU slice with operand inversion
module alu_bit_slice
  import alu_defs::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       a_inv,
  input  logic       b_inv,
  input  logic       cin,
  input  logic [1:0] sel,
  output logic       res,
  output logic       cout
);
  logic aa, bb;
  assign aa = a ^ a_inv;
  assign bb = b ^ b_inv;
  // a serial slice has no less input, so SEL_LESS yields 0
  always_comb begin
    res  = sel == SEL_AND ? aa & bb :
           sel == SEL_OR  ? aa | bb :
           sel == SEL_ADD ? aa ^ bb ^ cin : 1'b0;
    cout = (aa & bb) | (cin & (aa ^ bb));
  end
endmodule

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial ALU sequencer, one WIDTH-bit op over WIDTH cycles LSB-first
module alu_serial_seq
  import alu_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);
  localparam int CW = $clog2(WIDTH);
  state_t           state;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] a_sh, b_sh, work, sum, fin;
  logic [3:0]       op;
  logic             carry, s_res, s_cout, last, ovf;
  ctl_t             ctl, ctl_in;
  assign ctl    = decode(op);
  assign ctl_in = decode(ctrl_i);
  assign busy_o = state != S_IDLE;
  assign done_o = state == S_DONE;
  alu_bit_slice u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .a_inv(ctl.a_inv),
    .b_inv(ctl.b_inv),
    .cin  (carry),
    .sel  (ctl.sel),
    .res  (s_res),
    .cout (s_cout)
  );
  // on the last bit the carry register holds the MSB carry-in
  assign last = idx == CW'(WIDTH - 1);
  assign sum  = {s_res, work[WIDTH-1:1]};
  assign ovf  = carry ^ s_cout;
  assign fin  = !ctl.valid ? '0 :
                ctl.slt ? {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf} : sum;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= S_IDLE;
      idx        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      work       <= '0;
      op         <= '0;
      carry      <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b1;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (start_i) begin
          state <= S_RUN;
          a_sh  <= src1_i;
          b_sh  <= src2_i;
          op    <= ctrl_i;
          idx   <= '0;
          work  <= '0;
          carry <= ctl_in.valid & ctl_in.b_inv;
        end
        S_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          work  <= sum;
          carry <= s_cout;
          idx   <= idx + 1'b1;
          if (last) begin
            state      <= S_DONE;
            result_o   <= fin;
            zero_o     <= fin == '0;
            cout_o     <= ctl.valid & (ctl.arith | ctl.slt) & s_cout;
            overflow_o <= ctl.valid & ctl.arith & ovf;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: directed vectors checked against a cycle-countdown arithmetic model
module tb_alu_serial_seq;
  import alu_defs::*;
  localparam int W = 32;
  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;
  logic         clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0;
  logic [W-1:0] src1_i = '0, src2_i = '0;
  logic [3:0]   ctrl_i = '0;
  logic         busy_o, done_o, zero_o, cout_o, overflow_o;
  logic [W-1:0] result_o;
  int checks = 0, errors = 0;
  alu_serial_seq #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .src1_i(src1_i), .src2_i(src2_i),
    .ctrl_i(ctrl_i), .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .zero_o(zero_o), .cout_o(cout_o), .overflow_o(overflow_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  function automatic exp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    exp_t e;
    logic [W:0] s;
    e = '0;
    s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    case (op)
      OP_AND: e.r = a & b;
      OP_OR:  e.r = a | b;
      OP_NOR: e.r = ~(a | b);
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        e.r = s[W-1:0];
        e.c = s[W];
        e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      OP_SUB: begin
        e.r = s[W-1:0];
        e.c = s[W];
        e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      OP_SLT: begin
        e.r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
        e.c = s[W];
      end
      default: ;
    endcase
    e.z = e.r == '0;
    return e;
  endfunction
  // model: cnt counts cycles left of busy; outputs load as done begins
  int           cnt = 0;
  logic [W-1:0] pa = '0, pb = '0;
  logic [3:0]   pop = '0;
  exp_t         m = '{r: '0, z: 1'b1, c: 1'b0, v: 1'b0};
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= 0;
      m   <= '{r: '0, z: 1'b1, c: 1'b0, v: 1'b0};
    end else if (cnt == 0) begin
      if (start_i) begin
        cnt <= W + 1;
        pa  <= src1_i;
        pb  <= src2_i;
        pop <= ctrl_i;
      end
    end else begin
      cnt <= cnt - 1;
      if (cnt == 2) m <= ref_op(pa, pb, pop);
    end
  end
  always @(negedge clk_i) begin
    if (rst_i) begin
      chk("busy", 64'(busy_o), 64'(cnt != 0));
      chk("done", 64'(done_o), 64'(cnt == 1));
      chk("result", 64'(result_o), 64'(m.r));
      chk("zero", 64'(zero_o), 64'(m.z));
      chk("cout", 64'(cout_o), 64'(m.c));
      chk("ovf", 64'(overflow_o), 64'(m.v));
    end
  end
  task automatic run_op(input string n, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] op, input logic [W-1:0] er,
                        input logic ez, input logic ec, input logic ev);
    int k;
    @(negedge clk_i);
    src1_i = a; src2_i = b; ctrl_i = op; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; src1_i = $urandom; src2_i = $urandom; ctrl_i = OP_OR;
    k = 1;
    while (!done_o && k < 40) begin
      @(negedge clk_i);
      k++;
    end
    chk({n, "_latency"}, 64'(k), 64'(W + 1));
    chk({n, "_result"}, 64'(result_o), 64'(er));
    chk({n, "_flags"}, 64'({zero_o, cout_o, overflow_o}), 64'({ez, ec, ev}));
  endtask
  initial begin
    logic [3:0] ops [3];
    int dones, last;
    ops = '{OP_ADD, OP_SUB, OP_SLT};
    @(posedge clk_i);
    #1;
    chk("rst_state", 64'({busy_o, done_o, zero_o, cout_o, overflow_o}), 64'(5'b00100));
    chk("rst_result", 64'(result_o), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b1;
    run_op("add",  32'h0000_0005, 32'h0000_0003, OP_ADD, 32'h0000_0008, 0, 0, 0);
    run_op("sub",  32'h0000_0003, 32'h0000_0005, OP_SUB, 32'hFFFF_FFFE, 0, 0, 0);
    run_op("sub0", 32'h0000_0005, 32'h0000_0005, OP_SUB, 32'h0000_0000, 1, 1, 0);
    run_op("addv", 32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000, 0, 0, 1);
    run_op("slt",  32'hFFFF_FFFF, 32'h0000_0001, OP_SLT, 32'h0000_0001, 0, 1, 0);
    run_op("sltv", 32'h8000_0000, 32'h7FFF_FFFF, OP_SLT, 32'h0000_0001, 0, 1, 0);
    run_op("slt0", 32'h0000_0001, 32'hFFFF_FFFF, OP_SLT, 32'h0000_0000, 1, 0, 0);
    run_op("and",  32'hF0F0_F0F0, 32'h0F0F_0F00, OP_AND, 32'h0000_0000, 1, 0, 0);
    run_op("or",   32'h1234_0000, 32'h0000_5678, OP_OR,  32'h1234_5678, 0, 0, 0);
    run_op("bad",  32'hFFFF_FFFF, 32'h0000_0001, 4'b1111, 32'h0000_0000, 1, 0, 0);
    run_op("nor",  32'hF0F0_F0F0, 32'h0F0F_0F00, OP_NOR, 32'h0000_000F, 0, 0, 0);
    // start held high with operands changing every cycle
    @(negedge clk_i);
    start_i = 1'b1; src1_i = $urandom; src2_i = $urandom; ctrl_i = OP_ADD;
    dones = 0;
    last = -1;
    for (int k = 0; k < 102; k++) begin
      @(negedge clk_i);
      if (done_o) begin
        if (last >= 0) chk("b2b_gap", 64'(k - last), 64'(34));
        else chk("b2b_first", 64'(k), 64'(32));
        last = k;
        dones++;
      end
      src1_i = $urandom; src2_i = $urandom; ctrl_i = ops[k % 3];
    end
    start_i = 1'b0;
    chk("b2b_count", 64'(dones), 64'(3));
    repeat (3) @(negedge clk_i);
    // abort an ADD while bit 10 is in flight
    src1_i = 32'h0000_1234; src2_i = 32'h0000_1111; ctrl_i = OP_ADD; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("abort_state", 64'({busy_o, done_o, zero_o, cout_o, overflow_o}), 64'(5'b00100));
    chk("abort_result", 64'(result_o), 64'(0));
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b1;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) chk("abort_no_done", 64'(done_o), 64'(0));
    end
    run_op("after_rst", 32'h0000_0001, 32'h0000_0001, OP_ADD, 32'h0000_0002, 0, 0, 0);
    repeat (2) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
